// File: rtl/instr_fetch.sv
// Instruction fetch stage.
// Holds the program counter and instruction register, and issues one read request at a time to
// the instruction memory. Fetched words wait in a one-entry buffer until the control unit
// commits them to IR with IRWre. PC updates select the next PC from four sources through PCSrc.
// A halt opcode in IR freezes PC until reset.
module instr_fetch (
    input  logic        CLK,
    input  logic        RST,
    input  logic        PCWre,
    input  logic        IRWre,
    input  logic [1:0]  PCSrc,
    input  logic [31:0] ExtImm,
    input  logic [31:0] RegJump,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic        fetch_busy,
    output logic [31:0] PC,
    output logic [31:0] PC4,
    output logic [31:0] IR,
    output logic [5:0]  Opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [15:0] imm16,
    output logic        halted
);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StReq  = 2'b01,
        StHold = 2'b10
    } fetch_state_e;

    fetch_state_e state_q;
    logic [31:0]  pc_q;
    logic [31:0]  ir_q;
    logic [31:0]  fbuf_q;
    logic         fbuf_valid_q;

    logic [31:0]  pc_plus4;
    logic [31:0]  pc_next;
    logic         pc_load;
    logic         ir_load;

    // Next-PC selection; all sums wrap modulo 2^32.
    always_comb begin
        pc_plus4 = pc_q + 32'd4;
        pc_next  = pc_plus4;
        unique case (PCSrc)
            2'b00:   pc_next = pc_plus4;
            2'b01:   pc_next = pc_plus4 + (ExtImm << 2);
            2'b10:   pc_next = RegJump;
            2'b11:   pc_next = {pc_plus4[31:28], ir_q[25:0], 2'b00};
            default: pc_next = pc_plus4;
        endcase
    end

    // Halt blocks PC writes; IR only commits a valid buffered word while in HOLD.
    always_comb begin
        pc_load = PCWre && !halted;
        ir_load = (state_q == StHold) && IRWre && fbuf_valid_q;
    end

    // Fetch FSM, PC and fetch buffer. A PC write overrides any state, including a
    // same-cycle ack, so data fetched for the old PC is never buffered.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q      <= StIdle;
            pc_q         <= 32'd0;
            fbuf_q       <= 32'd0;
            fbuf_valid_q <= 1'b0;
        end else if (pc_load) begin
            state_q      <= StReq;
            pc_q         <= pc_next;
            fbuf_valid_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: state_q <= StReq;
                StReq: begin
                    if (imem_ack) begin
                        fbuf_q       <= imem_rdata;
                        fbuf_valid_q <= 1'b1;
                        state_q      <= StHold;
                    end
                end
                StHold: state_q <= StHold;
                default: begin
                    state_q      <= StIdle;
                    fbuf_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Instruction register; loads the buffer with its old-PC word even when PC moves this edge.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            ir_q <= 32'd0;
        end else if (ir_load) begin
            ir_q <= fbuf_q;
        end
    end

    // Outputs decoded from registered state and IR.
    always_comb begin
        imem_req   = (state_q == StReq);
        fetch_busy = (state_q == StReq);
        imem_addr  = pc_q;
        PC         = pc_q;
        PC4        = pc_plus4;
        IR         = ir_q;
        Opcode     = ir_q[31:26];
        rs         = ir_q[25:21];
        rt         = ir_q[20:16];
        rd         = ir_q[15:11];
        imm16      = ir_q[15:0];
        halted     = (ir_q[31:26] == 6'b111111);
    end

endmodule
